// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - nibble-serial wide add/sub/cmp/adc sequencer driving an external 4-bit ALU
module alu_nibble_seq #(
    parameter int NIBBLES = 2,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         flag_c_o,
    output logic         flag_z_o,
    output logic         flag_n_o,
    output logic         flag_v_o,
    output logic [3:0]   alu_a_o,
    output logic [3:0]   alu_b_o,
    output logic         alu_cin_o,
    output logic [1:0]   alu_op_o,
    output logic         alu_l_o,
    input  logic [3:0]   alu_r_i,
    input  logic         alu_cout_i,
    input  logic         alu_zero_i,
    input  logic         alu_sign_i
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_ADC = 2'b11;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [1:0]    kind_q, kind_d;
    logic [KW-1:0] k_q, k_d;
    logic          cr_q, cr_d;
    logic          za_q, za_d;
    logic [W-1:0]  tmp_q, tmp_d;
    logic [W-1:0]  result_q, result_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_n_q, flag_n_d;
    logic          flag_v_q, flag_v_d;
    logic [KW+1:0] sel;

    assign sel = {k_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        kind_d    = kind_q;
        k_d       = k_q;
        cr_d      = cr_q;
        za_d      = za_q;
        tmp_d     = tmp_q;
        result_d  = result_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        flag_v_d  = flag_v_q;
        alu_a_o   = 4'h0;
        alu_b_o   = 4'h0;
        alu_cin_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    opa_d   = a_i;
                    // Subtraction is A + ~B + 1, so the +1 rides in on the initial carry.
                    opb_d   = (op_i == OP_SUB || op_i == OP_CMP) ? ~b_i : b_i;
                    kind_d  = op_i;
                    k_d     = '0;
                    cr_d    = (op_i == OP_ADD) ? 1'b0 :
                              (op_i == OP_ADC) ? flag_c_q : 1'b1;
                    za_d    = 1'b1;
                end
            end
            S_RUN: begin
                alu_a_o          = opa_q[sel +: 4];
                alu_b_o          = opb_q[sel +: 4];
                alu_cin_o        = cr_q;
                tmp_d[sel +: 4]  = alu_r_i;
                cr_d             = alu_cout_i;
                za_d             = za_q & alu_zero_i;
                k_d              = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d  = S_DONE;
                    k_d      = '0;
                    flag_c_d = alu_cout_i;
                    flag_z_d = za_q & alu_zero_i;
                    flag_n_d = alu_sign_i;
                    flag_v_d = (opa_q[W-1] == opb_q[W-1]) & (alu_r_i[3] != opa_q[W-1]);
                    if (kind_q != OP_CMP) begin
                        result_d = tmp_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            kind_q   <= 2'b00;
            k_q      <= '0;
            cr_q     <= 1'b0;
            za_q     <= 1'b0;
            tmp_q    <= '0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            kind_q   <= kind_d;
            k_q      <= k_d;
            cr_q     <= cr_d;
            za_q     <= za_d;
            tmp_q    <= tmp_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign flag_c_o = flag_c_q;
    assign flag_z_o = flag_z_q;
    assign flag_n_o = flag_n_q;
    assign flag_v_o = flag_v_q;
    assign alu_op_o = 2'b10;
    assign alu_l_o  = 1'b0;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - randomized and directed bench for alu_nibble_seq with a 4-bit ALU model
module tb_alu_nibble_seq;

    localparam int NIBBLES = 2;
    localparam int W = 4 * NIBBLES;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o;
    logic [W-1:0] result_o;
    logic         flag_c_o, flag_z_o, flag_n_o, flag_v_o;
    logic [3:0]   alu_a_o, alu_b_o;
    logic         alu_cin_o;
    logic [1:0]   alu_op_o;
    logic         alu_l_o;
    logic [3:0]   alu_r_i;
    logic         alu_cout_i, alu_zero_i, alu_sign_i;
    logic [4:0]   alu_sum;

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .flag_c_o(flag_c_o), .flag_z_o(flag_z_o),
        .flag_n_o(flag_n_o), .flag_v_o(flag_v_o), .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o), .alu_cin_o(alu_cin_o), .alu_op_o(alu_op_o),
        .alu_l_o(alu_l_o), .alu_r_i(alu_r_i), .alu_cout_i(alu_cout_i),
        .alu_zero_i(alu_zero_i), .alu_sign_i(alu_sign_i)
    );

    // External combinational 4-bit ALU in its A+B+c_in mode
    assign alu_sum    = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {4'b0, alu_cin_o};
    assign alu_r_i    = alu_sum[3:0];
    assign alu_cout_i = alu_sum[4];
    assign alu_zero_i = (alu_sum[3:0] == 4'h0);
    assign alu_sign_i = alu_sum[3];

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_result = '0;
    logic         m_c = 0, m_z = 0, m_n = 0, m_v = 0;
    logic         m_cin0;

    int           obs_busy;
    logic         obs_done, obs_done_next;
    logic         obs_cin [NIBBLES];
    logic [3:0]   obs_a [NIBBLES];

    function automatic int sval(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    // Reference: whole-word arithmetic on integers, then flags from the word
    function automatic void model_apply(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, full, s;
        logic [W-1:0] r;
        ua = int'(a);
        ub = int'(b);
        if (op == 2'b01 || op == 2'b10) begin
            m_cin0 = 1'b1;
            full = ua - ub;
            m_c = (ua >= ub);
            s = sval(a) - sval(b);
        end else begin
            m_cin0 = (op == 2'b11) ? m_c : 1'b0;
            full = ua + ub + int'(m_cin0);
            m_c = (full >= (1 << W));
            s = sval(a) + sval(b) + int'(m_cin0);
        end
        r = W'(full);
        m_z = (r == '0);
        m_n = r[W-1];
        m_v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        if (op != 2'b10) m_result = r;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int cnt;
        model_apply(op, a, b);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        op_i = 2'($urandom); a_i = W'($urandom); b_i = W'($urandom);
        cnt = 0;
        while (busy_o && cnt < 20) begin
            if (cnt < NIBBLES) begin
                obs_cin[cnt] = alu_cin_o;
                obs_a[cnt] = alu_a_o;
            end
            cnt++;
            @(posedge clk_i); #1;
        end
        obs_busy = cnt;
        obs_done = done_o;
        @(posedge clk_i); #1;
        obs_done_next = done_o;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy_o, done_o, result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b res=%h cznv=%b%b%b%b want all 0",
                busy_o, done_o, result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o);
        end
        checks++;
        if ({alu_a_o, alu_b_o, alu_cin_o, alu_op_o, alu_l_o} !== {4'h0, 4'h0, 1'b0, 2'b10, 1'b0}) begin
            errors++; $display("FAIL reset_alu got a=%h b=%h cin=%b op=%b l=%b want 0 0 0 10 0",
                alu_a_o, alu_b_o, alu_cin_o, alu_op_o, alu_l_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_add;
        run_op(2'b00, 8'h3A, 8'h47);
        checks++;
        if (obs_busy !== NIBBLES || obs_done !== 1'b1 || obs_done_next !== 1'b0) begin
            errors++; $display("FAIL add_timing got busy_cycles=%0d done=%b done_next=%b want %0d 1 0",
                obs_busy, obs_done, obs_done_next, NIBBLES);
        end
        checks++;
        if ({obs_a[0], obs_a[1]} !== 8'hA3) begin
            errors++; $display("FAIL add_nibble_order got %h,%h want a,3", obs_a[0], obs_a[1]);
        end
        checks++;
        if ({result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o} !== {8'h81, 4'b0011}) begin
            errors++; $display("FAIL add_result got %h cznv=%b%b%b%b want 81 0011",
                result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o);
        end
    endtask

    task automatic test_sub;
        run_op(2'b01, 8'h50, 8'h50);
        checks++;
        if ({result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o} !== {8'h00, 4'b1100}) begin
            errors++; $display("FAIL sub_equal got %h cznv=%b%b%b%b want 00 1100",
                result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o);
        end
        run_op(2'b01, 8'h10, 8'h20);
        checks++;
        if ({result_o, flag_c_o, flag_n_o} !== {8'hF0, 2'b01}) begin
            errors++; $display("FAIL sub_borrow got %h c=%b n=%b want f0 c=0 n=1", result_o, flag_c_o, flag_n_o);
        end
    endtask

    task automatic test_cmp;
        run_op(2'b00, 8'h3A, 8'h47);
        run_op(2'b10, 8'h05, 8'h09);
        checks++;
        if ({result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o} !== {8'h81, 4'b0010}) begin
            errors++; $display("FAIL cmp_keep got %h cznv=%b%b%b%b want 81 0010",
                result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o);
        end
    endtask

    task automatic test_adc;
        run_op(2'b00, 8'hFF, 8'h01);
        checks++;
        if (flag_c_o !== 1'b1) begin
            errors++; $display("FAIL adc_preload got c=%b want 1", flag_c_o);
        end
        run_op(2'b11, 8'hFF, 8'h00);
        checks++;
        if ({result_o, flag_c_o, flag_z_o} !== {8'h00, 2'b11}) begin
            errors++; $display("FAIL adc_result got %h c=%b z=%b want 00 1 1", result_o, flag_c_o, flag_z_o);
        end
        checks++;
        if ({obs_cin[0], obs_cin[1]} !== 2'b11) begin
            errors++; $display("FAIL adc_cin_seq got %b,%b want 1,1", obs_cin[0], obs_cin[1]);
        end
    endtask

    task automatic test_start_held;
        int dones, busies;
        model_apply(2'b00, 8'h01, 8'h02);
        dones = 0; busies = 0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; a_i = 8'h01; b_i = 8'h02;
        // Held through RUN into DONE, then an extra pulse while in DONE
        for (int i = 0; i < NIBBLES + 1; i++) begin
            @(posedge clk_i); #1;
            a_i = 8'hEE;
            if (done_o) dones++;
            if (busy_o) busies++;
        end
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_o) dones++;
            if (busy_o) busies++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (dones !== 1 || busies !== NIBBLES) begin
            errors++; $display("FAIL start_held got dones=%0d busy_cycles=%0d want 1 %0d", dones, busies, NIBBLES);
        end
        checks++;
        if (result_o !== m_result) begin
            errors++; $display("FAIL start_held_result got %h want %h", result_o, m_result);
        end
        run_op(2'b00, 8'h20, 8'h22);
        checks++;
        if (obs_busy !== NIBBLES || obs_done !== 1'b1 || result_o !== 8'h42) begin
            errors++; $display("FAIL start_reassert got busy=%0d done=%b res=%h want %0d 1 42",
                obs_busy, obs_done, result_o, NIBBLES);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; a_i = 8'h77; b_i = 8'h11;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o, alu_a_o, alu_cin_o} !== '0) begin
            errors++; $display("FAIL reset_mid got busy=%b done=%b res=%h cznv=%b%b%b%b alu_a=%h cin=%b want 0",
                busy_o, done_o, result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o, alu_a_o, alu_cin_o);
        end
        m_result = '0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_hold got busy=%b done=%b want 0 0", busy_o, done_o);
        end
        rst_ni = 1'b1;
        run_op(2'b00, 8'h01, 8'h01);
        checks++;
        if (result_o !== 8'h02 || obs_done !== 1'b1) begin
            errors++; $display("FAIL reset_recover got res=%h done=%b want 02 1", result_o, obs_done);
        end
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = W'($urandom);
            b = (i % 8 == 0) ? a : W'($urandom);
            run_op(op, a, b);
            checks++;
            if ({result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o} !== {m_result, m_c, m_z, m_n, m_v}) begin
                errors++; $display("FAIL random_%0d op=%b a=%h b=%h got %h cznv=%b%b%b%b want %h %b%b%b%b",
                    i, op, a, b, result_o, flag_c_o, flag_z_o, flag_n_o, flag_v_o,
                    m_result, m_c, m_z, m_n, m_v);
            end
            checks++;
            if (obs_busy !== NIBBLES || obs_done !== 1'b1 || obs_cin[0] !== m_cin0) begin
                errors++; $display("FAIL random_proto_%0d got busy=%0d done=%b cin0=%b want %0d 1 %b",
                    i, obs_busy, obs_done, obs_cin[0], NIBBLES, m_cin0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_cmp;
        test_adc;
        test_start_held;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
